// File: rtl/multi_timer_pkg.sv
// Shared definitions for the multi-channel timer: FSM states, register offsets, mode codes.
// No logic of its own; imported by the channel and the top level.
// No flow control is involved.
package multi_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tmr_state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;

    // Reserved mode codes 10/11 fall back to one-shot behaviour.
    function automatic logic is_periodic(input logic [1:0] mode);
        return mode == MODE_PERIODIC;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: ctrl/preset/count/status registers plus IDLE-LOAD-CNT-INT FSM.
// Register writes land on the next edge; reads are combinational.
// Any write to this channel holds its FSM for that cycle; no other backpressure.
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  reg_sel,
    input  logic [31:0] din,
    output logic [31:0] rdata,
    output logic        irq
);

    tmr_state_t       state;
    tmr_state_t       state_nxt;
    logic             en;
    logic             en_nxt;
    logic [1:0]       mode;
    logic             im;
    logic [WIDTH-1:0] preset;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_nxt;
    logic             pend;
    logic             pend_set;
    logic             fsm_go;
    logic             wr_ctrl;
    logic             wr_preset;
    logic             wr_count;
    logic             wr_status;
    logic             unused_din;

    assign fsm_go    = !we;
    assign wr_ctrl   = we && (reg_sel == REG_CTRL);
    assign wr_preset = we && (reg_sel == REG_PRESET);
    assign wr_count  = we && (reg_sel == REG_COUNT);
    assign wr_status = we && (reg_sel == REG_STATUS);
    assign unused_din = ^din;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else if (fsm_go) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        en_nxt    = en;
        pend_set  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_nxt = preset;
                state_nxt = ST_CNT;
            end
            ST_CNT: begin
                // Presets of 0 and 1 both expire on the first counting cycle.
                if (!en) begin
                    state_nxt = ST_IDLE;
                end else if (count > WIDTH'(1)) begin
                    count_nxt = count - WIDTH'(1);
                end else begin
                    count_nxt = '0;
                    pend_set  = 1'b1;
                    state_nxt = ST_INT;
                end
            end
            ST_INT: begin
                if (is_periodic(mode)) begin
                    state_nxt = ST_LOAD;
                end else begin
                    en_nxt    = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en     <= 1'b0;
            mode   <= 2'b00;
            im     <= 1'b0;
            preset <= '0;
            count  <= '0;
            pend   <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en   <= din[0];
                mode <= din[2:1];
                im   <= din[3];
            end else if (fsm_go) begin
                en <= en_nxt;
            end

            if (wr_preset) begin
                preset <= din[WIDTH-1:0];
            end

            if (wr_count) begin
                count <= din[WIDTH-1:0];
            end else if (fsm_go) begin
                count <= count_nxt;
            end

            // Expiry beats a same-cycle clear so an interrupt is never lost.
            if (pend_set && fsm_go) begin
                pend <= 1'b1;
            end else if (wr_status && din[0]) begin
                pend <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_CTRL:   rdata = {28'd0, im, mode, en};
            REG_PRESET: rdata = 32'(preset);
            REG_COUNT:  rdata = 32'(count);
            REG_STATUS: rdata = {31'd0, pend};
            default:    rdata = '0;
        endcase
    end

    assign irq = pend & im;

endmodule

// File: rtl/multi_timer.sv
// NCH independent down-count timers behind a word-addressed register window.
// Writes take effect on the next edge; read data and interrupts are combinational.
// No backpressure; a write holds only the addressed channel's FSM for one cycle.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [31:0]    Addr,
    input  logic           WE,
    input  logic [31:0]    Din,
    output logic [31:0]    Dout,
    output logic [NCH-1:0] IRQ_vec,
    output logic           IRQ
);

    logic [2:0]  ch_sel;
    logic [1:0]  reg_sel;
    logic [31:0] ch_rdata [NCH];
    logic        unused_addr;

    assign ch_sel      = Addr[6:4];
    assign reg_sel     = Addr[3:2];
    assign unused_addr = ^{Addr[31:7], Addr[1:0]};

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic ch_we;
        assign ch_we = WE && (ch_sel == 3'(i));

        timer_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .we      (ch_we),
            .reg_sel (reg_sel),
            .din     (Din),
            .rdata   (ch_rdata[i]),
            .irq     (IRQ_vec[i])
        );
    end

    // Unpopulated channel slots match no index and read as zero.
    always_comb begin
        Dout = '0;
        for (int k = 0; k < NCH; k++) begin
            if (ch_sel == 3'(k)) begin
                Dout = ch_rdata[k];
            end
        end
    end

    assign IRQ = |IRQ_vec;

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: stimulus pushes expected values, a monitor pops and compares.
module tb_multi_timer;

    localparam int NCH   = 2;
    localparam int WIDTH = 32;

    localparam logic [1:0] R_CTRL = 2'd0;
    localparam logic [1:0] R_PRE  = 2'd1;
    localparam logic [1:0] R_CNT  = 2'd2;
    localparam logic [1:0] R_ST   = 2'd3;

    localparam int K_DOUT = 0;
    localparam int K_IRQ  = 1;
    localparam int K_VEC  = 2;

    logic           clk;
    logic           reset;
    logic [31:0]    Addr;
    logic           WE;
    logic [31:0]    Din;
    logic [31:0]    Dout;
    logic [NCH-1:0] IRQ_vec;
    logic           IRQ;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } chk_t;

    chk_t sb_q[$];
    logic chk_vld;
    int   n_cmp  = 0;
    int   n_fail = 0;

    multi_timer #(
        .NCH   (NCH),
        .WIDTH (WIDTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .Addr    (Addr),
        .WE      (WE),
        .Din     (Din),
        .Dout    (Dout),
        .IRQ_vec (IRQ_vec),
        .IRQ     (IRQ)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge chk_vld) begin : monitor
        chk_t        c;
        logic [31:0] act;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL monitor: output presented with empty scoreboard");
        end else begin
            c = sb_q.pop_front();
            case (c.kind)
                K_DOUT:  act = Dout;
                K_IRQ:   act = 32'(IRQ);
                default: act = 32'(IRQ_vec);
            endcase
            n_cmp++;
            if (act !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, act, c.exp);
            end
        end
    end

    function automatic logic [31:0] addr_of(input int ch, input logic [1:0] r);
        logic [2:0] c3;
        c3 = 3'(ch);
        return {25'd0, c3, r, 2'b00};
    endfunction

    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input logic [1:0] r, input logic [31:0] d);
        Addr = addr_of(ch, r);
        Din  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE   = 1'b0;
    endtask

    task automatic expect_out(input int kind, input logic [31:0] e, input string nm);
        chk_t c;
        c.name = nm;
        c.kind = kind;
        c.exp  = e;
        sb_q.push_back(c);
        #1 chk_vld = 1'b1;
        #1 chk_vld = 1'b0;
    endtask

    task automatic rd(input int ch, input logic [1:0] r, input logic [31:0] e, input string nm);
        Addr = addr_of(ch, r);
        expect_out(K_DOUT, e, nm);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset   = 1'b1;
        WE      = 1'b0;
        Addr    = '0;
        Din     = '0;
        chk_vld = 1'b0;
        #1 reset = 1'b0;
        #2;
        rd(0, R_CTRL, 0, "rst_ctrl");
        expect_out(K_IRQ, 0, "rst_irq");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        cycle(1);
        expect_out(K_IRQ, 0, "irq_first_edge");
        expect_out(K_VEC, 0, "vec_first_edge");
        rd(0, R_CNT, 0, "rst_count");
        rd(1, R_PRE, 0, "rst_preset");

        // One-shot, ch0 preset 5, EN+IM
        wr(0, R_PRE, 5);
        wr(0, R_CTRL, 32'h9);
        cycle(3);
        rd(0, R_CNT, 4, "os_count_e3");
        cycle(3);
        expect_out(K_IRQ, 0, "os_irq_e6");
        rd(0, R_CNT, 1, "os_count_e6");
        cycle(1);
        expect_out(K_IRQ, 1, "os_irq_e7");
        rd(0, R_CNT, 0, "os_count_e7");
        rd(0, R_ST, 1, "os_pend_e7");
        cycle(1);
        rd(0, R_CTRL, 32'h8, "os_ctrl_en_cleared");
        wr(0, R_ST, 1);
        expect_out(K_IRQ, 0, "os_irq_after_w1c");
        rd(0, R_ST, 0, "os_pend_after_w1c");

        // Periodic, ch1 preset 3
        wr(1, R_PRE, 3);
        wr(1, R_CTRL, 32'hB);
        cycle(4);
        rd(1, R_ST, 0, "per_pend_e4");
        cycle(1);
        rd(1, R_ST, 1, "per_pend_e5");
        expect_out(K_VEC, 2, "per_vec_e5");
        wr(1, R_ST, 1);
        rd(1, R_ST, 0, "per_pend_cleared");
        cycle(4);
        rd(1, R_ST, 0, "per_pend_ew4");
        cycle(1);
        rd(1, R_ST, 1, "per_pend_ew5");
        rd(1, R_CTRL, 32'hB, "per_en_kept");
        wr(1, R_CTRL, 0);
        wr(1, R_ST, 1);
        expect_out(K_IRQ, 0, "per_irq_off");

        // Independence: ch1 written every cycle while ch0 counts from 10
        wr(0, R_PRE, 10);
        wr(0, R_CTRL, 32'h1);
        cycle(3);
        rd(0, R_CNT, 9, "ind_count_e3");
        for (int k = 0; k < 4; k++) wr(1, R_PRE, 32'(100 + k));
        rd(0, R_CNT, 5, "ind_count_e7");
        rd(1, R_PRE, 103, "ind_ch1_preset");
        cycle(1);
        rd(0, R_CNT, 4, "ind_count_e8");
        wr(0, R_CTRL, 0);
        cycle(2);
        rd(0, R_CNT, 4, "ind_count_held");
        rd(0, R_CTRL, 0, "ind_ctrl_off");

        // Disable while count is 7
        wr(0, R_PRE, 9);
        wr(0, R_CTRL, 32'h1);
        cycle(3);
        rd(0, R_CNT, 8, "dis_count_e3");
        cycle(1);
        rd(0, R_CNT, 7, "dis_count_e4");
        wr(0, R_CTRL, 0);
        cycle(3);
        rd(0, R_CNT, 7, "dis_count_held");
        rd(0, R_ST, 0, "dis_no_pend");

        // Out-of-range channel writes and reads
        wr(2, R_CTRL, 32'hF);
        wr(2, R_PRE, 32'h55);
        wr(7, R_CNT, 32'h66);
        rd(2, R_CTRL, 0, "oor_ctrl");
        rd(2, R_PRE, 0, "oor_preset");
        rd(0, R_CTRL, 0, "oor_ch0_ctrl");
        rd(0, R_PRE, 9, "oor_ch0_preset");
        cycle(1);
        rd(1, R_PRE, 103, "oor_ch1_preset");
        rd(0, R_CNT, 7, "oor_ch0_count");
        rd(7, R_CNT, 0, "oor_ch7_count");

        // Preset 0 expires on first CNT cycle
        wr(0, R_PRE, 0);
        wr(0, R_CTRL, 32'h9);
        cycle(2);
        rd(0, R_ST, 0, "p0_pend_e2");
        cycle(1);
        rd(0, R_ST, 1, "p0_pend_e3");
        rd(0, R_CNT, 0, "p0_count");
        cycle(1);
        rd(0, R_CTRL, 32'h8, "p0_ctrl");
        wr(0, R_ST, 1);

        // Preset 1, reserved mode 10 acts as one-shot; then sticky PEND
        wr(0, R_PRE, 1);
        wr(0, R_CTRL, 32'hD);
        cycle(2);
        rd(0, R_ST, 0, "p1_pend_e2");
        cycle(1);
        rd(0, R_ST, 1, "p1_pend_e3");
        cycle(1);
        rd(0, R_CTRL, 32'hC, "m10_ctrl");
        rd(0, R_CNT, 0, "m10_count");
        wr(0, R_CTRL, 0);
        rd(0, R_ST, 1, "sticky_pend");
        expect_out(K_IRQ, 0, "sticky_irq_masked");
        wr(0, R_ST, 1);
        rd(0, R_ST, 0, "sticky_cleared");

        // Collision: W1C on the cycle ch1 would enter INT
        wr(1, R_PRE, 2);
        wr(1, R_CTRL, 32'h9);
        cycle(3);
        wr(1, R_ST, 1);
        cycle(1);
        rd(1, R_ST, 1, "col_pend");
        expect_out(K_IRQ, 1, "col_irq");
        cycle(1);
        rd(1, R_ST, 1, "col_pend_later");
        rd(1, R_CTRL, 32'h8, "col_ctrl");
        wr(1, R_ST, 1);
        expect_out(K_IRQ, 0, "col_irq_cleared");

        // Reset asserted mid-count
        wr(0, R_PRE, 5);
        wr(0, R_CTRL, 32'h9);
        cycle(4);
        rd(0, R_CNT, 3, "rm_count_before");
        reset = 1'b0;
        rd(0, R_CNT, 0, "rm_count");
        rd(0, R_CTRL, 0, "rm_ctrl");
        rd(0, R_PRE, 0, "rm_preset");
        expect_out(K_IRQ, 0, "rm_irq");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        cycle(1);
        expect_out(K_IRQ, 0, "rm_irq_first_edge");
        cycle(10);
        expect_out(K_IRQ, 0, "rm_no_irq_later");
        rd(0, R_ST, 0, "rm_no_pend");
        rd(0, R_CNT, 0, "rm_count_later");

        #5;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
